// File: rtl/flash_responder.sv
// Deterministic stand-in for the cartridge board flash part: latches word
// addresses, serves latency-delayed burst reads and accepts single-word writes.
module flash_responder #(
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 2
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic        I_FLASH_CLK,
  input  logic [23:0] I_FLASH_ADDR,
  input  logic        I_ADDR_VALID_L,
  input  logic        I_FLASH_CE_L,
  input  logic        I_FLASH_OE_L,
  input  logic        I_FLASH_WE_L,
  inout  logic [15:0] IO_FLASH_DATA,
  output logic        O_FLASH_WAIT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LAT   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [2:0] LAT_INIT = 3'(LATENCY - 1);

  logic [1:0]        state;
  logic [MEM_AW-1:0] addr;
  logic [MEM_AW-1:0] addr_in;
  logic [MEM_AW-1:0] addr_inc;
  logic [2:0]        lat_cnt;
  logic [15:0]       rdata;
  logic              fclk_q;
  logic              fedge;
  logic              mem_we;
  logic              bus_drive;
  logic              addr_unused;

  logic [15:0] mem [0:(1 << MEM_AW) - 1];

  assign fedge       = I_FLASH_CLK & ~fclk_q;
  assign addr_in     = I_FLASH_ADDR[MEM_AW-1:0];
  assign addr_inc    = addr + MEM_AW'(1);
  assign addr_unused = ^I_FLASH_ADDR[23:MEM_AW];

  assign mem_we = I_RESET_L && fedge && !I_FLASH_CE_L && !I_FLASH_WE_L &&
                  (state == ST_WRITE);

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state   <= ST_IDLE;
      addr    <= '0;
      lat_cnt <= '0;
      rdata   <= '0;
      fclk_q  <= 1'b0;
    end else begin
      fclk_q <= I_FLASH_CLK;
      // Deselect wins over everything, including a same-edge address strobe.
      if (I_FLASH_CE_L) begin
        state <= ST_IDLE;
      end else if (fedge) begin
        if (!I_ADDR_VALID_L && state != ST_WRITE) begin
          addr <= addr_in;
          if (!I_FLASH_WE_L) begin
            state <= ST_WRITE;
          end else if (LATENCY == 1) begin
            state <= ST_BURST;
            rdata <= mem[addr_in];
          end else begin
            state   <= ST_LAT;
            lat_cnt <= LAT_INIT;
          end
        end else begin
          case (state)
            ST_LAT: begin
              if (lat_cnt == '0) begin
                state <= ST_BURST;
                rdata <= mem[addr];
              end else begin
                lat_cnt <= lat_cnt - 3'd1;
              end
            end
            ST_BURST: begin
              addr  <= addr_inc;
              rdata <= mem[addr_inc];
            end
            ST_WRITE: begin
              if (!I_FLASH_WE_L) state <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // No reset on the array: contents persist across reset like the real part.
  always_ff @(posedge I_CLK) begin
    if (mem_we) mem[addr] <= IO_FLASH_DATA;
  end

  assign bus_drive     = (state == ST_BURST) && !I_FLASH_CE_L && !I_FLASH_OE_L &&
                         I_FLASH_WE_L;
  assign IO_FLASH_DATA = bus_drive ? rdata : 'z;
  assign O_FLASH_WAIT  = (state == ST_LAT);

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder; the data bus is pulled up so a released
// bus reads back as 16'hFFFF.
module tb_flash_responder;

  logic        I_CLK;
  logic        I_RESET_L;
  logic        I_FLASH_CLK;
  logic [23:0] I_FLASH_ADDR;
  logic        I_ADDR_VALID_L;
  logic        I_FLASH_CE_L;
  logic        I_FLASH_OE_L;
  logic        I_FLASH_WE_L;
  logic        O_FLASH_WAIT;
  tri1  [15:0] flash_data;

  logic [15:0] drv;
  logic        drv_en;
  logic [15:0] bus_s;
  logic        wait_s;

  int unsigned n_vec;
  int unsigned n_err;

  localparam logic [15:0] BUS_Z = 16'hFFFF;

  assign flash_data = drv_en ? drv : 'z;

  flash_responder #(.MEM_AW(10), .LATENCY(2)) dut (
    .I_CLK          (I_CLK),
    .I_RESET_L      (I_RESET_L),
    .I_FLASH_CLK    (I_FLASH_CLK),
    .I_FLASH_ADDR   (I_FLASH_ADDR),
    .I_ADDR_VALID_L (I_ADDR_VALID_L),
    .I_FLASH_CE_L   (I_FLASH_CE_L),
    .I_FLASH_OE_L   (I_FLASH_OE_L),
    .I_FLASH_WE_L   (I_FLASH_WE_L),
    .IO_FLASH_DATA  (flash_data),
    .O_FLASH_WAIT   (O_FLASH_WAIT)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One flash clock cycle: 2 I_CLK high, 2 low; outputs captured just after the fedge edge.
  task automatic fcyc();
    I_FLASH_CLK = 1'b1;
    @(negedge I_CLK);
    bus_s  = flash_data;
    wait_s = O_FLASH_WAIT;
    @(negedge I_CLK);
    I_FLASH_CLK = 1'b0;
    @(negedge I_CLK);
    @(negedge I_CLK);
  endtask

  task automatic idle_bus();
    I_FLASH_CE_L   = 1'b1;
    I_ADDR_VALID_L = 1'b1;
    I_FLASH_WE_L   = 1'b1;
    I_FLASH_OE_L   = 1'b1;
    drv_en         = 1'b0;
    fcyc();
  endtask

  task automatic flash_write(input logic [23:0] a, input logic [15:0] d);
    I_FLASH_CE_L   = 1'b0;
    I_ADDR_VALID_L = 1'b0;
    I_FLASH_WE_L   = 1'b0;
    I_FLASH_OE_L   = 1'b1;
    I_FLASH_ADDR   = a;
    fcyc();
    I_ADDR_VALID_L = 1'b1;
    drv            = d;
    drv_en         = 1'b1;
    fcyc();
    idle_bus();
  endtask

  // Latch a read address; leaves bus in read mode after the latch fedge.
  task automatic read_latch(input logic [23:0] a);
    drv_en         = 1'b0;
    I_FLASH_CE_L   = 1'b0;
    I_ADDR_VALID_L = 1'b0;
    I_FLASH_WE_L   = 1'b1;
    I_FLASH_OE_L   = 1'b0;
    I_FLASH_ADDR   = a;
    fcyc();
    I_ADDR_VALID_L = 1'b1;
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    I_RESET_L      = 1'b0;
    I_FLASH_CLK    = 1'b0;
    I_FLASH_ADDR   = '0;
    I_ADDR_VALID_L = 1'b1;
    I_FLASH_CE_L   = 1'b1;
    I_FLASH_OE_L   = 1'b1;
    I_FLASH_WE_L   = 1'b1;
    drv            = '0;
    drv_en         = 1'b0;

    // Reset held with random inputs toggling
    for (int i = 0; i < 12; i++) begin
      @(negedge I_CLK);
      I_FLASH_CLK    = 1'($urandom);
      I_FLASH_ADDR   = 24'($urandom);
      I_ADDR_VALID_L = 1'($urandom);
      I_FLASH_CE_L   = 1'($urandom);
      I_FLASH_OE_L   = 1'($urandom);
      I_FLASH_WE_L   = 1'($urandom);
      #1;
      chk("rst_bus", flash_data, BUS_Z);
      chk("rst_wait", {15'd0, O_FLASH_WAIT}, 16'd0);
    end
    @(negedge I_CLK);
    I_FLASH_CLK = 1'b0;
    I_FLASH_CE_L = 1'b1;
    I_ADDR_VALID_L = 1'b1;
    I_FLASH_WE_L = 1'b1;
    I_FLASH_OE_L = 1'b1;
    @(negedge I_CLK);
    I_RESET_L = 1'b1;
    @(negedge I_CLK);
    @(negedge I_CLK);
    chk("post_rst_wait", {15'd0, O_FLASH_WAIT}, 16'd0);

    flash_write(24'h000010, 16'hBEEF);
    flash_write(24'h000011, 16'h1234);
    flash_write(24'h0003FF, 16'hA5A5);
    flash_write(24'h000000, 16'h5A5A);

    // Read from 0x10: WAIT for two fedges, then BEEF, 1234
    read_latch(24'h000010);
    chk("rd_lat_wait0", {15'd0, wait_s}, 16'd1);
    chk("rd_lat_bus0", bus_s, BUS_Z);
    fcyc();
    chk("rd_lat_wait1", {15'd0, wait_s}, 16'd1);
    fcyc();
    chk("rd_w0_wait", {15'd0, wait_s}, 16'd0);
    chk("rd_w0", bus_s, 16'hBEEF);
    fcyc();
    chk("rd_w1", bus_s, 16'h1234);
    idle_bus();

    // Wrap 0x3FF -> 0x000
    read_latch(24'h0003FF);
    fcyc();
    fcyc();
    chk("wrap_w0", bus_s, 16'hA5A5);
    fcyc();
    chk("wrap_w1", bus_s, 16'h5A5A);
    idle_bus();

    // CE abort on the second burst word
    read_latch(24'h000010);
    fcyc();
    fcyc();
    chk("abort_w0", bus_s, 16'hBEEF);
    I_FLASH_CE_L = 1'b1;
    fcyc();
    chk("abort_bus", bus_s, BUS_Z);
    chk("abort_wait", {15'd0, wait_s}, 16'd0);
    I_FLASH_CE_L = 1'b0;
    #1;
    chk("abort_idle_bus", flash_data, BUS_Z);
    idle_bus();

    // Re-latch mid-burst to 0x3FF
    read_latch(24'h000010);
    fcyc();
    fcyc();
    chk("relatch_w0", bus_s, 16'hBEEF);
    I_ADDR_VALID_L = 1'b0;
    I_FLASH_ADDR   = 24'h0003FF;
    fcyc();
    I_ADDR_VALID_L = 1'b1;
    chk("relatch_wait0", {15'd0, wait_s}, 16'd1);
    chk("relatch_bus0", bus_s, BUS_Z);
    fcyc();
    chk("relatch_wait1", {15'd0, wait_s}, 16'd1);
    fcyc();
    chk("relatch_wait2", {15'd0, wait_s}, 16'd0);
    chk("relatch_w", bus_s, 16'hA5A5);

    // CE_L=1 with ADV_L=0 on a fedge: deselect wins
    I_FLASH_CE_L   = 1'b1;
    I_ADDR_VALID_L = 1'b0;
    I_FLASH_ADDR   = 24'h000010;
    fcyc();
    I_FLASH_CE_L   = 1'b0;
    I_ADDR_VALID_L = 1'b1;
    #1;
    chk("ce_adv_wait", {15'd0, O_FLASH_WAIT}, 16'd0);
    chk("ce_adv_bus", flash_data, BUS_Z);
    idle_bus();

    // Reset during latency
    read_latch(24'h000010);
    chk("rstlat_wait_pre", {15'd0, wait_s}, 16'd1);
    I_RESET_L = 1'b0;
    #1;
    chk("rstlat_wait", {15'd0, O_FLASH_WAIT}, 16'd0);
    chk("rstlat_bus", flash_data, BUS_Z);
    @(negedge I_CLK);
    I_RESET_L = 1'b1;
    idle_bus();

    read_latch(24'h000010);
    fcyc();
    fcyc();
    chk("keep_w0", bus_s, 16'hBEEF);
    fcyc();
    chk("keep_w1", bus_s, 16'h1234);
    idle_bus();
    read_latch(24'h0003FF);
    fcyc();
    fcyc();
    chk("keep_w2", bus_s, 16'hA5A5);
    fcyc();
    chk("keep_w3", bus_s, 16'h5A5A);
    idle_bus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
